// File: rtl/vec_wb_pkg.sv
// Shared constants and types for the vector register file writeback path.
package vec_wb_pkg;

  localparam int VLEN   = 256;
  localparam int LANE_W = 32;
  localparam int LANES  = VLEN / LANE_W;
  localparam int RA_W   = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } wb_state_t;

  typedef logic [$clog2(LANES)-1:0] lane_cnt_t;

endpackage

// File: rtl/vec_lane_buffer.sv
// Assembly buffer: gathers LANE_W-bit memory beats into one VLEN-bit vector.
module vec_lane_buffer
  import vec_wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_en,
  input  lane_cnt_t         idx,
  input  logic [LANE_W-1:0] lane_data,
  output logic [VLEN-1:0]   vec
);

  // Store one beat into its lane slot; reset or clear wipes the whole vector.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      vec <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (idx == lane_cnt_t'(i)) begin
          vec[i*LANE_W +: LANE_W] <= lane_data;
        end
      end
    end
  end

endmodule

// File: rtl/vec_wb.sv
// Writeback driver for the vector register file write port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no load in flight; accepts a load announce
// COLLECT | gathering memory lanes into the assembly buffer
// WRITE   | buffer complete; next edge writes it (ALU path blocked)
module vec_wb_writer
  import vec_wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [RA_W-1:0]   alu_rd,
  input  logic [VLEN-1:0]   alu_data,
  input  logic              ld_start_valid,
  output logic              ld_start_ready,
  input  logic [RA_W-1:0]   ld_rd,
  input  logic              lane_valid,
  output logic              lane_ready,
  input  logic [LANE_W-1:0] lane_data,
  output logic              WriteEn,
  output logic [RA_W-1:0]   rd,
  output logic [VLEN-1:0]   InputData,
  output logic              ld_done,
  output logic              busy
);

  wb_state_t        state, state_nxt;
  lane_cnt_t        count;
  logic [RA_W-1:0]  ld_rd_q;
  logic [VLEN-1:0]  buf_vec;
  logic             ld_start_hs;
  logic             lane_hs;
  logic             alu_hs;

  assign ld_start_hs = ld_start_valid && ld_start_ready;
  assign lane_hs     = lane_valid && lane_ready;
  assign alu_hs      = alu_valid && alu_ready;

  // Handshake readies and next-state decode.
  always_comb begin
    state_nxt      = state;
    ld_start_ready = (state == IDLE);
    lane_ready     = (state == COLLECT);
    alu_ready      = (state != WRITE);
    busy           = (state != IDLE);
    case (state)
      IDLE:    if (ld_start_valid) state_nxt = COLLECT;
      COLLECT: if (lane_hs && count == lane_cnt_t'(LANES-1)) state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, lane counter and latched load destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      ld_rd_q <= '0;
    end else begin
      state <= state_nxt;
      if (ld_start_hs) begin
        count   <= '0;
        ld_rd_q <= ld_rd;
      end else if (lane_hs) begin
        count <= count + 1'b1;
      end
    end
  end

  // Buffer is cleared on each new load so a stale vector can never leak.
  vec_lane_buffer u_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (ld_start_hs),
    .wr_en     (lane_hs),
    .idx       (count),
    .lane_data (lane_data),
    .vec       (buf_vec)
  );

  // Registered write port; WRITE has priority, alu_ready already excludes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      WriteEn   <= 1'b0;
      rd        <= '0;
      InputData <= '0;
      ld_done   <= 1'b0;
    end else if (state == WRITE) begin
      WriteEn   <= 1'b1;
      rd        <= ld_rd_q;
      InputData <= buf_vec;
      ld_done   <= 1'b1;
    end else if (alu_hs) begin
      WriteEn   <= 1'b1;
      rd        <= alu_rd;
      InputData <= alu_data;
      ld_done   <= 1'b0;
    end else begin
      WriteEn   <= 1'b0;
      ld_done   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vec_wb_writer.sv
// Directed bench for vec_wb_writer with hand-computed expectations.
module tb_vec_wb_writer;

  logic         clk = 1'b0;
  logic         rst;
  logic         alu_valid;
  logic         alu_ready;
  logic [4:0]   alu_rd;
  logic [255:0] alu_data;
  logic         ld_start_valid;
  logic         ld_start_ready;
  logic [4:0]   ld_rd;
  logic         lane_valid;
  logic         lane_ready;
  logic [31:0]  lane_data;
  logic         WriteEn;
  logic [4:0]   rd;
  logic [255:0] InputData;
  logic         ld_done;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done_pulses = 0;
  int n_wr_pulses   = 0;

  localparam logic [255:0] VEC_1TO8 =
    256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;

  vec_wb_writer dut (
    .clk            (clk),
    .rst            (rst),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .ld_start_valid (ld_start_valid),
    .ld_start_ready (ld_start_ready),
    .ld_rd          (ld_rd),
    .lane_valid     (lane_valid),
    .lane_ready     (lane_ready),
    .lane_data      (lane_data),
    .WriteEn        (WriteEn),
    .rd             (rd),
    .InputData      (InputData),
    .ld_done        (ld_done),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ld_done) n_done_pulses++;
    if (WriteEn) n_wr_pulses++;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [4:0] r);
    ld_start_valid = 1'b1;
    ld_rd          = r;
    check("ld_start_ready_idle", ld_start_ready, 1'b1);
    tick();
    ld_start_valid = 1'b0;
    check("busy_collect", busy, 1'b1);
  endtask

  task automatic send_lane(input logic [31:0] d);
    int guard;
    lane_valid = 1'b1;
    lane_data  = d;
    guard = 0;
    while (!lane_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (guard >= 20) check("lane_ready_timeout", 1'b0, 1'b1);
    tick();
    lane_valid = 1'b0;
  endtask

  function automatic logic [255:0] pat_vec(input logic [31:0] base, input logic [31:0] step);
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = base + step * k;
    return v;
  endfunction

  initial begin
    int done0, wr0;
    logic [255:0] v;

    rst = 1'b1; alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_start_valid = 0; ld_rd = 0; lane_valid = 0; lane_data = 0;
    tick(); tick();
    rst = 1'b0;
    check("rst_WriteEn", WriteEn, 1'b0);
    check("rst_rd", rd, 5'd0);
    check("rst_InputData", InputData, 256'd0);
    check("rst_ld_done", ld_done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_alu_ready", alu_ready, 1'b1);
    check("rst_lane_ready", lane_ready, 1'b0);

    // ALU direct write
    alu_valid = 1'b1; alu_rd = 5'd18; alu_data = 256'd100;
    check("alu_ready_idle", alu_ready, 1'b1);
    tick();
    alu_valid = 1'b0;
    check("alu_we", WriteEn, 1'b1);
    check("alu_rd", rd, 5'd18);
    check("alu_data", InputData, 256'd100);
    tick();
    check("alu_we_once", WriteEn, 1'b0);
    check("alu_rd_hold", rd, 5'd18);
    check("alu_data_hold", InputData, 256'd100);

    // Reset mid-COLLECT after three lanes
    wr0 = n_wr_pulses;
    start_load(5'd9);
    send_lane(32'hDEAD0001); send_lane(32'hDEAD0002); send_lane(32'hDEAD0003);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("mid_rst_WriteEn", WriteEn, 1'b0);
    check("mid_rst_rd", rd, 5'd0);
    check("mid_rst_InputData", InputData, 256'd0);
    check("mid_rst_busy", busy, 1'b0);
    tick(); tick();
    check("mid_rst_no_write", n_wr_pulses - wr0, 0);

    // Load after reset: only the new lanes appear
    start_load(5'd16);
    for (int k = 0; k < 8; k++) send_lane(32'h11111111 * (k + 1));
    check("ld_n1_we", WriteEn, 1'b0);
    check("ld_n1_alu_ready", alu_ready, 1'b0);
    check("ld_n1_busy", busy, 1'b1);
    tick();
    check("ld_we", WriteEn, 1'b1);
    check("ld_done", ld_done, 1'b1);
    check("ld_rd", rd, 5'd16);
    check("ld_data", InputData, VEC_1TO8);
    check("ld_start_ready_n2", ld_start_ready, 1'b1);
    tick();
    check("ld_we_once", WriteEn, 1'b0);
    check("ld_done_once", ld_done, 1'b0);

    // Lane gaps
    wr0 = n_wr_pulses;
    start_load(5'd16);
    for (int k = 0; k < 8; k++) begin
      send_lane(32'h11111111 * (k + 1));
      if (k != 7) begin
        check("gap_no_we", WriteEn, 1'b0);
        tick();
      end
    end
    check("gap_n1_we", WriteEn, 1'b0);
    tick();
    check("gap_we", WriteEn, 1'b1);
    check("gap_data", InputData, VEC_1TO8);
    tick();
    check("gap_one_write", n_wr_pulses - wr0, 1);

    // Interleaved ALU write, plus ALU held across the WRITE cycle
    start_load(5'd20);
    for (int k = 0; k < 4; k++) send_lane(32'hC0DE0000 + k);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 256'hABCD;
    check("il_alu_ready_collect", alu_ready, 1'b1);
    tick();
    alu_valid = 1'b0;
    check("il_alu_we", WriteEn, 1'b1);
    check("il_alu_rd", rd, 5'd5);
    check("il_alu_data", InputData, 256'hABCD);
    for (int k = 4; k < 8; k++) send_lane(32'hC0DE0000 + k);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 256'd77;
    check("il_alu_ready_write", alu_ready, 1'b0);
    tick();
    check("il_ld_we", WriteEn, 1'b1);
    check("il_ld_rd", rd, 5'd20);
    check("il_ld_data", InputData, pat_vec(32'hC0DE0000, 32'd1));
    check("il_ld_done", ld_done, 1'b1);
    check("il_alu_ready_after", alu_ready, 1'b1);
    tick();
    alu_valid = 1'b0;
    check("il_alu2_we", WriteEn, 1'b1);
    check("il_alu2_rd", rd, 5'd7);
    check("il_alu2_data", InputData, 256'd77);
    check("il_alu2_not_ld", ld_done, 1'b0);
    tick();

    // Back-to-back loads with ld_start_valid held
    done0 = n_done_pulses;
    start_load(5'd3);
    ld_start_valid = 1'b1; ld_rd = 5'd4;
    check("b2b_start_blocked", ld_start_ready, 1'b0);
    for (int k = 0; k < 8; k++) send_lane(32'hA0000000 + k);
    check("b2b_start_blocked_n1", ld_start_ready, 1'b0);
    tick();
    check("b2b_first_rd", rd, 5'd3);
    check("b2b_first_data", InputData, pat_vec(32'hA0000000, 32'd1));
    check("b2b_start_ready_n2", ld_start_ready, 1'b1);
    tick();
    ld_start_valid = 1'b0;
    check("b2b_second_accepted", lane_ready, 1'b1);
    for (int k = 0; k < 8; k++) send_lane(32'hB0000000 + 32'h10 * k);
    tick();
    check("b2b_second_we", WriteEn, 1'b1);
    check("b2b_second_rd", rd, 5'd4);
    v = pat_vec(32'hB0000000, 32'h10);
    check("b2b_second_data", InputData, v);
    tick();
    check("b2b_two_done", n_done_pulses - done0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
